// File: rtl/core_pkg.sv
// core_pkg: core-wide widths and the fetch bundle type shared between the
// fetch stage, the fetch queue and decode.
//   FETCH_WIDTH    : instruction slots delivered per fetch bundle
//   XLEN           : PC and instruction word width
//   FQ_DEPTH       : default number of bundle entries in the fetch queue
//   fetch_bundle_t : one fetch bundle (slot valids, PCs, instruction words)
package core_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int XLEN        = 32;
  localparam int FQ_DEPTH    = 4;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]           valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
  } fetch_bundle_t;

endpackage : core_pkg

// File: rtl/fetch_queue_ctrl_fq_storage.sv
// fq_storage: DEPTH-entry register array of fetch bundles for the fetch
// queue. One synchronous write port and one asynchronous read port, so
// the head entry falls straight through to the read data. The array
// holds data only and is never reset; occupancy is tracked by the owner.
//   clk     : core clock
//   wr_en   : write wr_data into entry wr_addr at the next posedge
//   wr_addr : entry written (tail pointer)
//   wr_data : bundle written
//   rd_addr : entry read (head pointer)
//   rd_data : contents of entry rd_addr, combinational
module fq_storage
  import core_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  fetch_bundle_t wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fetch_bundle_t rd_data
);

  fetch_bundle_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : fq_storage

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: bundle-granular instruction queue between fetch and
// decode. Fetch bundles are written at the tail and the oldest bundle is
// presented first-word-fall-through to decode/rename. Back-pressure to
// fetch comes from registered occupancy only (fetch_stall_req == q_full),
// so there is no combinational path from rename_ready back to fetch.
// A flush drops every held bundle plus whatever arrives in the flush cycle.
//
// Ports:
//   clk, reset        : core clock; synchronous active-low reset
//   if_valid/pc/instr : incoming fetch bundle (all-zero valid = no bundle)
//   flush             : redirect; empties the queue next cycle
//   rename_ready      : decode/rename takes the head bundle this cycle
//   fetch_stall_req   : fetch must hold its bundle (queue full)
//   q_valid/pc/instr  : head bundle; q_valid is 0 when empty
//   q_count           : bundles held, 0..DEPTH
//   q_empty, q_full   : occupancy flags derived from q_count
//   perf_full_cycles  : saturating count of cycles spent full
module fetch_queue_ctrl
  import core_pkg::*;
#(
  parameter int DEPTH       = FQ_DEPTH,
  parameter int FETCH_WIDTH = core_pkg::FETCH_WIDTH,
  parameter int XLEN        = core_pkg::XLEN,
  parameter int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [FETCH_WIDTH-1:0]           if_valid,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0] if_pc,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0] if_instr,
  input  logic                           flush,
  input  logic                           rename_ready,
  output logic                           fetch_stall_req,
  output logic [FETCH_WIDTH-1:0]           q_valid,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] q_pc,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] q_instr,
  output logic [CNT_W-1:0]               q_count,
  output logic                           q_empty,
  output logic                           q_full,
  output logic [31:0]                    perf_full_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Saturating increment for the full-cycle performance counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      perf_cnt;

  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] count_nxt;

  fetch_bundle_t    wr_bundle;
  fetch_bundle_t    head_bundle;

  // Occupancy flags come from the registered count only; pointer equality
  // cannot distinguish full from empty.
  assign q_empty         = (count == '0);
  assign q_full          = (count == FULL_CNT);
  assign fetch_stall_req = q_full;
  assign q_count         = count;
  assign perf_full_cycles = perf_cnt;

  // Full blocks enqueue even when the head leaves this cycle; that is what
  // keeps rename_ready out of the fetch stall path.
  assign enq = (|if_valid) && !q_full && !flush;
  assign deq = rename_ready && !q_empty && !flush;

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    wr_bundle       = '0;
    wr_bundle.valid = if_valid;
    wr_bundle.pc    = if_pc;
    wr_bundle.instr = if_instr;
  end

  // ---- storage write (tail) / asynchronous read (head) ----
  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (tail),
    .wr_data (wr_bundle),
    .rd_addr (head),
    .rd_data (head_bundle)
  );

  // ---- control registers: pointers, occupancy, perf counter ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      perf_cnt <= '0;
    end else begin
      if (q_full) begin
        perf_cnt <= sat_inc32(perf_cnt);
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
        if (enq) tail <= tail + PTR_W'(1);
        if (deq) head <= head + PTR_W'(1);
        count <= count_nxt;
      end
    end
  end

  // ---- head bundle presentation ----
  // Storage contents are stale when empty, so only the valids are masked.
  assign q_valid = q_empty ? '0 : head_bundle.valid;
  assign q_pc    = head_bundle.pc;
  assign q_instr = head_bundle.instr;

endmodule : fetch_queue_ctrl

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: a table of single-cycle vectors
// (reset, basic enqueue/dequeue, fill/stall/drain) followed by hand-written
// sequences for wrap-around, flush, empty bundles and mid-run reset.
module tb_fetch_queue_ctrl;

  localparam int FW = 2;
  localparam int XL = 32;

  logic                    clk;
  logic                    reset;
  logic [FW-1:0]           if_valid;
  logic [FW-1:0][XL-1:0]   if_pc;
  logic [FW-1:0][XL-1:0]   if_instr;
  logic                    flush;
  logic                    rename_ready;
  logic                    fetch_stall_req;
  logic [FW-1:0]           q_valid;
  logic [FW-1:0][XL-1:0]   q_pc;
  logic [FW-1:0][XL-1:0]   q_instr;
  logic [2:0]              q_count;
  logic                    q_empty;
  logic                    q_full;
  logic [31:0]             perf_full_cycles;

  int checks;
  int failures;

  fetch_queue_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .flush            (flush),
    .rename_ready     (rename_ready),
    .fetch_stall_req  (fetch_stall_req),
    .q_valid          (q_valid),
    .q_pc             (q_pc),
    .q_instr          (q_instr),
    .q_count          (q_count),
    .q_empty          (q_empty),
    .q_full           (q_full),
    .perf_full_cycles (perf_full_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic        rr;
    logic [1:0]  v;
    logic [31:0] pc;
    logic [31:0] ins;
    int          cnt;
    logic        emp;
    logic        full;
    logic [1:0]  qv;
    logic [31:0] epc;
    logic [31:0] eins;
    int          perf;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Second slot of every bundle is derived from the first.
  task automatic drive(input logic rst_n, input logic fl, input logic rr,
                       input logic [1:0] v, input logic [31:0] pc,
                       input logic [31:0] ins);
    reset        = rst_n;
    flush        = fl;
    rename_ready = rr;
    if_valid     = v;
    if_pc[0]     = pc;
    if_pc[1]     = pc + 32'd4;
    if_instr[0]  = ins;
    if_instr[1]  = ins + 32'h2000_0001;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".pc0"},    64'(q_pc[0]),    64'(pc));
    chk({tag, ".pc1"},    64'(q_pc[1]),    64'(pc + 32'd4));
    chk({tag, ".instr0"}, 64'(q_instr[0]), 64'(ins));
    chk({tag, ".instr1"}, 64'(q_instr[1]), 64'(ins + 32'h2000_0001));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    //             rst fl rr v      pc        ins            cnt emp full qv     epc       eins         perf
    vecs[0]  = '{1'b0,1'b0,1'b0,2'b00,32'h0,  32'h0,         0, 1'b1,1'b0,2'b00,32'h0,   32'h0,         0};
    vecs[1]  = '{1'b0,1'b0,1'b0,2'b00,32'h0,  32'h0,         0, 1'b1,1'b0,2'b00,32'h0,   32'h0,         0};
    vecs[2]  = '{1'b1,1'b0,1'b0,2'b00,32'h0,  32'h0,         0, 1'b1,1'b0,2'b00,32'h0,   32'h0,         0};
    vecs[3]  = '{1'b1,1'b0,1'b0,2'b11,32'h100,32'h2000_0001, 1, 1'b0,1'b0,2'b11,32'h100, 32'h2000_0001, 0};
    vecs[4]  = '{1'b1,1'b0,1'b1,2'b00,32'h0,  32'h0,         0, 1'b1,1'b0,2'b00,32'h0,   32'h0,         0};
    vecs[5]  = '{1'b1,1'b0,1'b0,2'b11,32'h0,  32'h00A0_0000, 1, 1'b0,1'b0,2'b11,32'h0,   32'h00A0_0000, 0};
    vecs[6]  = '{1'b1,1'b0,1'b0,2'b11,32'h8,  32'h00A0_0008, 2, 1'b0,1'b0,2'b11,32'h0,   32'h00A0_0000, 0};
    vecs[7]  = '{1'b1,1'b0,1'b0,2'b11,32'h10, 32'h00A0_0010, 3, 1'b0,1'b0,2'b11,32'h0,   32'h00A0_0000, 0};
    vecs[8]  = '{1'b1,1'b0,1'b0,2'b11,32'h18, 32'h00A0_0018, 4, 1'b0,1'b1,2'b11,32'h0,   32'h00A0_0000, 0};
    vecs[9]  = '{1'b1,1'b0,1'b0,2'b11,32'h20, 32'h00A0_0020, 4, 1'b0,1'b1,2'b11,32'h0,   32'h00A0_0000, 1};
    vecs[10] = '{1'b1,1'b0,1'b0,2'b11,32'h20, 32'h00A0_0020, 4, 1'b0,1'b1,2'b11,32'h0,   32'h00A0_0000, 2};
    vecs[11] = '{1'b1,1'b0,1'b0,2'b11,32'h20, 32'h00A0_0020, 4, 1'b0,1'b1,2'b11,32'h0,   32'h00A0_0000, 3};
    vecs[12] = '{1'b1,1'b0,1'b1,2'b00,32'h0,  32'h0,         3, 1'b0,1'b0,2'b11,32'h8,   32'h00A0_0008, 4};
    vecs[13] = '{1'b1,1'b0,1'b1,2'b00,32'h0,  32'h0,         2, 1'b0,1'b0,2'b11,32'h10,  32'h00A0_0010, 4};
    vecs[14] = '{1'b1,1'b0,1'b1,2'b00,32'h0,  32'h0,         1, 1'b0,1'b0,2'b11,32'h18,  32'h00A0_0018, 4};
    vecs[15] = '{1'b1,1'b0,1'b1,2'b00,32'h0,  32'h0,         0, 1'b1,1'b0,2'b00,32'h0,   32'h0,         4};

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst_n, vecs[i].fl, vecs[i].rr, vecs[i].v, vecs[i].pc, vecs[i].ins);
      tick();
      chk({tag, ".count"}, 64'(q_count), 64'(vecs[i].cnt));
      chk({tag, ".empty"}, 64'(q_empty), 64'(vecs[i].emp));
      chk({tag, ".full"},  64'(q_full),  64'(vecs[i].full));
      chk({tag, ".stall"}, 64'(fetch_stall_req), 64'(vecs[i].full));
      chk({tag, ".qvalid"}, 64'(q_valid), 64'(vecs[i].qv));
      chk({tag, ".perf"},  64'(perf_full_cycles), 64'(vecs[i].perf));
      if (vecs[i].qv != 2'b00) chk_head(tag, vecs[i].epc, vecs[i].eins);
    end

    // Sustained enqueue + dequeue across two pointer wraps.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h1000, 32'h0B00_0000);
    tick();
    chk("wrap.prime.count", 64'(q_count), 64'd1);
    for (int n = 1; n <= 10; n++) begin
      string tag;
      logic [31:0] exp_pc;
      tag    = $sformatf("wrap%0d", n);
      exp_pc = 32'h1000 + 32'(8 * n);
      drive(1'b1, 1'b0, 1'b1, 2'b11, exp_pc, 32'h0B00_0000 + 32'(n));
      tick();
      chk({tag, ".count"},  64'(q_count), 64'd1);
      chk({tag, ".qvalid"}, 64'(q_valid), 64'(2'b11));
      chk_head(tag, exp_pc, 32'h0B00_0000 + 32'(n));
    end
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    tick();
    chk("wrap.drain.empty", 64'(q_empty), 64'd1);

    // Flush with a coincident enqueue and dequeue at q_count == 3.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b11, 32'hA00 + 32'(8 * n), 32'h0C00_0000 + 32'(n));
      tick();
    end
    chk("flush.pre.count", 64'(q_count), 64'd3);
    drive(1'b1, 1'b1, 1'b1, 2'b11, 32'hBAD0, 32'h0DEA_D000);
    tick();
    chk("flush.count",  64'(q_count), 64'd0);
    chk("flush.qvalid", 64'(q_valid), 64'd0);
    chk("flush.empty",  64'(q_empty), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'hC00, 32'h0E00_0000);
    tick();
    chk("flush.after.count", 64'(q_count), 64'd1);
    chk_head("flush.after", 32'hC00, 32'h0E00_0000);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    tick();
    chk("flush.drain.empty", 64'(q_empty), 64'd1);

    // All-zero valids are never stored.
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h500, 32'h0F00_0000);
      tick();
      chk($sformatf("novalid%0d.count", n), 64'(q_count), 64'd0);
    end

    // Reset in the middle of operation.
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h600 + 32'(8 * n), 32'h0100_0000);
      tick();
    end
    chk("rst.pre.count", 64'(q_count), 64'd2);
    chk("rst.pre.qvalid", 64'(q_valid), 64'(2'b01));
    chk("rst.pre.perf", 64'(perf_full_cycles), 64'd4);
    drive(1'b0, 1'b0, 1'b0, 2'b11, 32'h700, 32'h0200_0000);
    tick();
    chk("rst.count",  64'(q_count), 64'd0);
    chk("rst.full",   64'(q_full), 64'd0);
    chk("rst.empty",  64'(q_empty), 64'd1);
    chk("rst.qvalid", 64'(q_valid), 64'd0);
    chk("rst.perf",   64'(perf_full_cycles), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_queue_ctrl
